// File: rtl/u16_dec_ascii_tx.sv
// Converts a 16-bit unsigned value to decimal ASCII, most significant digit first, on a valid/ready byte stream.
// Define DEC_TX_TERM_EN to append TERM_CHAR as the final byte of each number.
module u16_dec_ascii_tx #(
    parameter int         UUID      = 0,
    parameter             NAME      = "",
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy
);

`ifdef DEC_TX_TERM_EN
    localparam logic LAST_ON_DIGIT = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_TERM} state_t;
`else
    localparam logic LAST_ON_DIGIT = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;
`endif

    if (UUID < 0) begin : g_bad_uuid
        $error("u16_dec_ascii_tx %s: negative UUID %0d (term %h)", NAME, UUID, TERM_CHAR);
    end

    state_t      state;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [3:0]  cnt_q;
    logic [2:0]  idx_q;

    logic [15:0] bcd_adj;
    logic [19:0] bcd_step;
    logic [2:0]  msd;

    function automatic logic [7:0] ascii_digit(input logic [19:0] bcd, input logic [2:0] i);
        return {4'h3, bcd[{i, 2'b00} +: 4]};
    endfunction

    // The top digit never needs the +3 correction: it is at most 3 before its final shift,
    // because 65535 < 80000.
    always_comb begin
        bcd_adj = bcd_q[15:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_step = {bcd_q[18:16], bcd_adj, bin_q[15]};
        msd = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_step[i*4 +: 4] != 4'd0)
                msd = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_q    <= in_data;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_step;
                    bin_q <= {bin_q[14:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        idx_q <= msd;
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // First EMIT cycle loads the leading digit; later bytes load on each handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= ascii_digit(bcd_q, idx_q);
                        out_last  <= LAST_ON_DIGIT && (idx_q == 3'd0);
                    end else if (out_ready) begin
                        if (idx_q != 3'd0) begin
                            idx_q    <= idx_q - 3'd1;
                            out_data <= ascii_digit(bcd_q, idx_q - 3'd1);
                            out_last <= LAST_ON_DIGIT && (idx_q == 3'd1);
                        end else begin
`ifdef DEC_TX_TERM_EN
                            out_data <= TERM_CHAR;
                            out_last <= 1'b1;
                            state    <= S_TERM;
`else
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef DEC_TX_TERM_EN
                S_TERM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= 8'h00;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
